// File: rtl/jpc_idecode_q.sv
// jpc_idecode_q -- queued RV32I instruction decoder between fetch and execute.
//
// Fetched instructions and their PCs go into a DEPTH-entry FIFO. The FIFO
// head is decoded combinationally and captured into a registered output
// stage. Both sides use valid/ready handshakes, so one instruction per
// cycle can flow through.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   instr_I, pc_I       fetched instruction and its PC
//   instr_valid_I       fetch side valid
//   instr_ready_O       FIFO has room (derived from pointers, no register)
//   flush_I             drops everything queued and in the output stage
//   decode_ready_I      consumer accepts the output stage
//   decode_valid_O      output stage holds a decoded instruction
//   pc_O .. rs2_O       raw instruction fields plus PC of the decoded entry
//   imm32_O             format-dependent immediate
//   ecall_O .. csr_O    special-instruction flags
//   error_O             illegal or unsupported encoding (flags forced to 0)
//   level_O             FIFO occupancy (output stage not included)
module jpc_idecode_q #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PC_WIDTH   = 32,
  parameter bit          ENABLE_CSR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr_I,
  input  logic [PC_WIDTH-1:0]     pc_I,
  input  logic                    instr_valid_I,
  output logic                    instr_ready_O,
  input  logic                    flush_I,
  input  logic                    decode_ready_I,
  output logic                    decode_valid_O,
  output logic [PC_WIDTH-1:0]     pc_O,
  output logic [6:0]              opcode_O,
  output logic [2:0]              funct3_O,
  output logic [6:0]              funct7_O,
  output logic [4:0]              rd_O,
  output logic [4:0]              rs1_O,
  output logic [4:0]              rs2_O,
  output logic [31:0]             imm32_O,
  output logic                    ecall_O,
  output logic                    ebreak_O,
  output logic                    fence_O,
  output logic                    fence_i_O,
  output logic                    csr_O,
  output logic                    error_O,
  output logic [$clog2(DEPTH):0]  level_O
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ---------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty differ.
  // ---------------------------------------------------------------------
  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic [AW:0]         level;
  logic                push;
  logic                load;
  logic                fifo_empty;

  assign level         = wptr - rptr;
  assign level_O       = level;
  assign fifo_empty    = (level == '0);
  assign instr_ready_O = (level < FULL_LEVEL);

  // Flush wins over both sides of the FIFO.
  assign push = instr_valid_I && instr_ready_O && !flush_I;
  assign load = !fifo_empty && (!decode_valid_O || decode_ready_I) && !flush_I;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_I) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr[AW-1:0]] <= instr_I;
      pc_mem[wptr[AW-1:0]]    <= pc_I;
    end
  end

  // ---------------------------------------------------------------------
  // Combinational decode of the FIFO head.
  // ---------------------------------------------------------------------
  logic [31:0]         head;
  logic [PC_WIDTH-1:0] head_pc;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [11:0]         imm12;
  logic [31:0]         d_imm;
  logic                d_ecall;
  logic                d_ebreak;
  logic                d_fence;
  logic                d_fence_i;
  logic                d_csr;
  logic                d_err;

  assign head    = instr_mem[rptr[AW-1:0]];
  assign head_pc = pc_mem[rptr[AW-1:0]];
  assign f3      = head[14:12];
  assign f7      = head[31:25];
  assign imm12   = head[31:20];

  always_comb begin
    d_imm     = '0;
    d_ecall   = 1'b0;
    d_ebreak  = 1'b0;
    d_fence   = 1'b0;
    d_fence_i = 1'b0;
    d_csr     = 1'b0;
    d_err     = 1'b0;
    case (head[6:0])
      OP_LUI, OP_AUIPC: begin
        d_imm = {head[31:12], 12'b0};
      end
      OP_JAL: begin
        d_imm = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};
      end
      OP_JALR: begin
        d_imm = {{20{head[31]}}, imm12};
        d_err = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        d_imm = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
        d_err = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        d_imm = {{20{head[31]}}, imm12};
        d_err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        d_imm = {{20{head[31]}}, head[31:25], head[11:7]};
        d_err = (f3 >= 3'b011);
      end
      OP_IMM: begin
        d_imm = {{20{head[31]}}, imm12};
        // Shift-immediates reuse funct7: only SRAI may set bit 30.
        if (f3 == 3'b001)
          d_err = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          d_err = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OP_OP: begin
        if (f7 == 7'b0100000)
          d_err = (f3 != 3'b000) && (f3 != 3'b101);
        else
          d_err = (f7 != 7'b0000000);
      end
      OP_MISC: begin
        case (f3)
          3'b000:  d_fence   = 1'b1;
          3'b001:  d_fence_i = 1'b1;
          default: d_err     = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          if (imm12 == 12'd0)
            d_ecall = 1'b1;
          else if (imm12 == 12'd1)
            d_ebreak = 1'b1;
          else
            d_err = 1'b1;
        end else if (f3 == 3'b100) begin
          d_err = 1'b1;
        end else begin
          // CSR forms: the rs1 field is a zero-extended immediate for CSRR*I.
          if (f3[2]) d_imm = {27'b0, head[19:15]};
          if (ENABLE_CSR) d_csr = 1'b1;
          else            d_err = 1'b1;
        end
      end
      default: begin
        d_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered output stage.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decode_valid_O <= 1'b0;
      pc_O           <= '0;
      opcode_O       <= '0;
      funct3_O       <= '0;
      funct7_O       <= '0;
      rd_O           <= '0;
      rs1_O          <= '0;
      rs2_O          <= '0;
      imm32_O        <= '0;
      ecall_O        <= 1'b0;
      ebreak_O       <= 1'b0;
      fence_O        <= 1'b0;
      fence_i_O      <= 1'b0;
      csr_O          <= 1'b0;
      error_O        <= 1'b0;
    end else if (flush_I) begin
      decode_valid_O <= 1'b0;
    end else if (load) begin
      decode_valid_O <= 1'b1;
      pc_O           <= head_pc;
      opcode_O       <= head[6:0];
      funct3_O       <= f3;
      funct7_O       <= f7;
      rd_O           <= head[11:7];
      rs1_O          <= head[19:15];
      rs2_O          <= head[24:20];
      imm32_O        <= d_imm;
      ecall_O        <= d_ecall;
      ebreak_O       <= d_ebreak;
      fence_O        <= d_fence;
      fence_i_O      <= d_fence_i;
      csr_O          <= d_csr;
      error_O        <= d_err;
    end else if (decode_ready_I) begin
      decode_valid_O <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpc_idecode_q.sv
// Testbench for jpc_idecode_q: two instances (CSR decode on / off) share one
// input stream; a scoreboard queue holds expectations pushed on each accepted
// instruction and compares them when the output stage is consumed.
module tb_jpc_idecode_q;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  flg;   // {ecall, ebreak, fence, fence_i, csr}
    logic        err;
  } dexp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    dexp_t       a;
    dexp_t       b;
  } ent_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [4:0]  fa;
    logic        ea;
    logic [4:0]  fb;
    logic        eb;
  } dir_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        decode_ready = 1'b0;

  logic          ready_a, dv_a, ecall_a, ebreak_a, fence_a, fencei_a, csr_a, err_a;
  logic [31:0]   pc_a, imm_a;
  logic [6:0]    op_a, f7_a;
  logic [2:0]    f3_a;
  logic [4:0]    rd_a, rs1_a, rs2_a;
  logic [LW-1:0] lvl_a;

  logic          ready_b, dv_b, ecall_b, ebreak_b, fence_b, fencei_b, csr_b, err_b;
  logic [31:0]   pc_b, imm_b;
  logic [6:0]    op_b, f7_b;
  logic [2:0]    f3_b;
  logic [4:0]    rd_b, rs1_b, rs2_b;
  logic [LW-1:0] lvl_b;

  int   n_checks = 0;
  int   n_fail = 0;
  ent_t sb[$];
  ent_t cur = '0;
  bit   rand_ready = 1'b0;

  jpc_idecode_q #(.DEPTH(DEPTH), .PC_WIDTH(32), .ENABLE_CSR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .instr_I(instr), .pc_I(pc), .instr_valid_I(instr_valid),
    .instr_ready_O(ready_a), .flush_I(flush), .decode_ready_I(decode_ready),
    .decode_valid_O(dv_a), .pc_O(pc_a), .opcode_O(op_a), .funct3_O(f3_a),
    .funct7_O(f7_a), .rd_O(rd_a), .rs1_O(rs1_a), .rs2_O(rs2_a), .imm32_O(imm_a),
    .ecall_O(ecall_a), .ebreak_O(ebreak_a), .fence_O(fence_a), .fence_i_O(fencei_a),
    .csr_O(csr_a), .error_O(err_a), .level_O(lvl_a));

  jpc_idecode_q #(.DEPTH(DEPTH), .PC_WIDTH(32), .ENABLE_CSR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .instr_I(instr), .pc_I(pc), .instr_valid_I(instr_valid),
    .instr_ready_O(ready_b), .flush_I(flush), .decode_ready_I(decode_ready),
    .decode_valid_O(dv_b), .pc_O(pc_b), .opcode_O(op_b), .funct3_O(f3_b),
    .funct7_O(f7_b), .rd_O(rd_b), .rs1_O(rs1_b), .rs2_O(rs2_b), .imm32_O(imm_b),
    .ecall_O(ecall_b), .ebreak_O(ebreak_b), .fence_O(fence_b), .fence_i_O(fencei_b),
    .csr_O(csr_b), .error_O(err_b), .level_O(lvl_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the RV32I encoding tables.
  function automatic dexp_t model(input logic [31:0] i, input bit csr_en);
    dexp_t       e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    e  = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h37, 7'h17: e.imm = {i[31:12], 12'h000};
      7'h6F: e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      7'h67: begin e.imm = {{20{i[31]}}, i[31:20]}; e.err = (f3 != 0); end
      7'h63: begin
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.err = (f3 == 2) || (f3 == 3);
      end
      7'h03: begin e.imm = {{20{i[31]}}, i[31:20]}; e.err = (f3 == 3) || (f3 >= 6); end
      7'h23: begin e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.err = (f3 >= 3); end
      7'h13: begin
        e.imm = {{20{i[31]}}, i[31:20]};
        e.err = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20));
      end
      7'h33: e.err = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      7'h0F: begin
        if (f3 == 0)      e.flg = 5'b00100;
        else if (f3 == 1) e.flg = 5'b00010;
        else              e.err = 1'b1;
      end
      7'h73: begin
        if (f3 == 0) begin
          if (i[31:20] == 0)      e.flg = 5'b10000;
          else if (i[31:20] == 1) e.flg = 5'b01000;
          else                    e.err = 1'b1;
        end else if (f3 == 4) begin
          e.err = 1'b1;
        end else begin
          if (f3 >= 5) e.imm = {27'd0, i[19:15]};
          if (csr_en) e.flg = 5'b00001;
          else        e.err = 1'b1;
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard monitor: samples mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    ent_t e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (dv_a && decode_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {32'd0, pc_a}, 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("pc",     pc_a,  e.pc);
          check("opcode", op_a,  e.instr[6:0]);
          check("rd",     rd_a,  e.instr[11:7]);
          check("funct3", f3_a,  e.instr[14:12]);
          check("rs1",    rs1_a, e.instr[19:15]);
          check("rs2",    rs2_a, e.instr[24:20]);
          check("funct7", f7_a,  e.instr[31:25]);
          check("imm",    imm_a, e.a.imm);
          check("flags",  {ecall_a, ebreak_a, fence_a, fencei_a, csr_a}, e.a.flg);
          check("error",  err_a, e.a.err);
          check("b_valid", dv_b, 1);
          check("b_pc",    pc_b, e.pc);
          check("b_imm",   imm_b, e.b.imm);
          check("b_flags", {ecall_b, ebreak_b, fence_b, fencei_b, csr_b}, e.b.flg);
          check("b_error", err_b, e.b.err);
        end
      end
      if (instr_valid && ready_a) sb.push_back(cur);
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pcv,
                      input dexp_t ea, input dexp_t eb);
    bit acc;
    acc = 1'b0;
    instr = ins;
    pc = pcv;
    cur.instr = ins;
    cur.pc = pcv;
    cur.a = ea;
    cur.b = eb;
    instr_valid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      acc = ready_a;
      @(posedge clk);
      #1;
      if (rand_ready) decode_ready = ($urandom_range(0, 3) != 0);
    end
    if (!acc) check("send_timeout", 0, 1);
    instr_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] ins, input logic [31:0] pcv);
    send(ins, pcv, model(ins, 1'b1), model(ins, 1'b0));
  endtask

  dir_t dirs [18] = '{
    '{32'h00500093, 32'h00000005, 5'b00000, 1'b0, 5'b00000, 1'b0},
    '{32'hFFFFF0B7, 32'hFFFFF000, 5'b00000, 1'b0, 5'b00000, 1'b0},
    '{32'hFE000EE3, 32'hFFFFFFFC, 5'b00000, 1'b0, 5'b00000, 1'b0},
    '{32'h40000033, 32'h00000000, 5'b00000, 1'b0, 5'b00000, 1'b0},
    '{32'h40001033, 32'h00000000, 5'b00000, 1'b1, 5'b00000, 1'b1},
    '{32'h00100073, 32'h00000000, 5'b01000, 1'b0, 5'b01000, 1'b0},
    '{32'h30002573, 32'h00000000, 5'b00001, 1'b0, 5'b00000, 1'b1},
    '{32'h00000073, 32'h00000000, 5'b10000, 1'b0, 5'b10000, 1'b0},
    '{32'h0000000F, 32'h00000000, 5'b00100, 1'b0, 5'b00100, 1'b0},
    '{32'h0000100F, 32'h00000000, 5'b00010, 1'b0, 5'b00010, 1'b0},
    '{32'h3052D073, 32'h00000005, 5'b00001, 1'b0, 5'b00000, 1'b1},
    '{32'h00003003, 32'h00000000, 5'b00000, 1'b1, 5'b00000, 1'b1},
    '{32'h00200073, 32'h00000000, 5'b00000, 1'b1, 5'b00000, 1'b1},
    '{32'h00000000, 32'h00000000, 5'b00000, 1'b1, 5'b00000, 1'b1},
    '{32'h008000EF, 32'h00000008, 5'b00000, 1'b0, 5'b00000, 1'b0},
    '{32'hFE112E23, 32'hFFFFFFFC, 5'b00000, 1'b0, 5'b00000, 1'b0},
    '{32'h40101013, 32'h00000401, 5'b00000, 1'b1, 5'b00000, 1'b1},
    '{32'h40105013, 32'h00000401, 5'b00000, 1'b0, 5'b00000, 1'b0}
  };

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  task automatic drain();
    int n;
    decode_ready = 1'b1;
    rand_ready = 1'b0;
    n = 0;
    while ((sb.size() != 0 || dv_a) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", (n < 100), 1);
  endtask

  initial begin
    dexp_t       ea, eb;
    logic [31:0] r;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", dv_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_level", lvl_a, 0);
    check("rst_pc",    pc_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: accept at edge k, valid after edge k+1
    decode_ready = 1'b1;
    ea = '0; ea.imm = 32'd5;
    send(32'h00500093, 32'h100, ea, ea);
    check("lat_valid_k", dv_a, 0);
    check("lat_level_k", lvl_a, 1);
    @(posedge clk);
    #1;
    check("lat_valid_k1", dv_a, 1);
    check("lat_rd",  rd_a, 1);
    check("lat_rs1", rs1_a, 0);
    check("lat_imm", imm_a, 32'h5);
    check("lat_pc",  pc_a, 32'h100);
    check("lat_err", err_a, 0);
    drain();

    // Fill: DEPTH in the FIFO plus one in the output stage
    decode_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++)
      send_model(32'h00000013 | (32'(k + 1) << 20) | (32'(k + 1) << 7), 32'h200 + 32'(4 * k));
    check("full_ready", ready_a, 0);
    check("full_level", lvl_a, DEPTH);
    check("full_valid", dv_a, 1);
    @(posedge clk);
    #1;
    check("hold_valid", dv_a, 1);
    check("hold_pc",    pc_a, 32'h200);
    decode_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      @(negedge clk);
      check("drain_valid", dv_a, 1);
    end
    @(negedge clk);
    check("drained_valid", dv_a, 0);
    check("drained_level", lvl_a, 0);

    // Directed encodings, streamed back to back
    @(posedge clk);
    #1;
    for (int k = 0; k < 18; k++) begin
      ea.imm = dirs[k].imm; ea.flg = dirs[k].fa; ea.err = dirs[k].ea;
      eb.imm = dirs[k].imm; eb.flg = dirs[k].fb; eb.err = dirs[k].eb;
      send(dirs[k].ins, 32'h1000 + 32'(4 * k), ea, eb);
    end
    drain();

    // Random encodings with random back-pressure and gaps
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      send_model(r, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Flush with three queued and a push in the same cycle
    decode_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_model(32'h00100093 + (32'(k) << 7), 32'h300 + 32'(4 * k));
    check("pre_flush_level", lvl_a, 3);
    check("pre_flush_valid", dv_a, 1);
    instr = 32'h7FF00113;
    pc = 32'hDEAD0000;
    instr_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    instr_valid = 1'b0;
    check("flush_valid", dv_a, 0);
    check("flush_level", lvl_a, 0);
    check("flush_ready", ready_a, 1);
    decode_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("post_flush_valid", dv_a, 0);
    end

    // Asynchronous reset mid-operation
    decode_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_model(32'h00208033, 32'h400 + 32'(4 * k));
    check("pre_rst_level", lvl_a, 2);
    check("pre_rst_valid", dv_a, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", dv_a, 0);
    check("mid_rst_level", lvl_a, 0);
    check("mid_rst_ready", ready_a, 1);
    check("mid_rst_pc",    pc_a, 0);
    check("mid_rst_rd",    rd_a, 0);
    check("mid_rst_b_valid", dv_b, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Recovery after reset
    decode_ready = 1'b1;
    send_model(32'h3052D073, 32'h500);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jpc_idecode_q.md
Name: jpc_idecode_q

Overview:
- Queued, fully-pipelined RV32I instruction decoder sitting between fetch and execute.
- Buffers fetched instructions and their PCs in a parametrised FIFO and decodes the FIFO head into a registered output stage.
- Uses standard valid/ready on both sides, so it sustains one instruction per cycle.
- Adds R-type, optional CSR decode, per-opcode funct3/funct7 legality checks, PC pass-through, flush and a fill-level report.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2.
PC_WIDTH, 32, width of the PC carried with each instruction.
ENABLE_CSR, 1, 1 = decode CSR* instructions; 0 = flag them as errors.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_I  in  32  fetched instruction
pc_I  in  PC_WIDTH  PC of instr_I
instr_valid_I  in  1  instr_I/pc_I valid
instr_ready_O  out  1  FIFO can accept
flush_I  in  1  discard all queued and output-stage instructions
decode_ready_I  in  1  consumer accepts output
decode_valid_O  out  1  decoded outputs valid
pc_O  out  PC_WIDTH  PC of the decoded instruction
opcode_O  out  7  instr[6:0]
funct3_O  out  3  instr[14:12]
funct7_O  out  7  instr[31:25]
rd_O  out  5  instr[11:7]
rs1_O  out  5  instr[19:15]
rs2_O  out  5  instr[24:20]
imm32_O  out  32  format-dependent immediate
ecall_O, ebreak_O, fence_O, fence_i_O, csr_O  out  1 each  special-instruction flags
error_O  out  1  illegal or unsupported encoding
level_O  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: reset clk, asynchronous, active-high; rst asynchronously clears FIFO pointers and all outputs to 0, except instr_ready_O = 1. Reset mid-operation drops all in-flight instructions.
- Input accept: an instruction is accepted on a rising edge with instr_valid_I && instr_ready_O. instr_ready_O = (level < DEPTH), registered-free (derived from pointers).
- Output stage: loads the FIFO head when the FIFO is non-empty and (!decode_valid_O || decode_ready_I). Outputs and decode_valid_O hold stable while decode_valid_O && !decode_ready_I.
- Latency: an instruction accepted at edge k into an empty block drives decode_valid_O = 1 after edge k+1.
- Throughput: one instruction per cycle. Simultaneous push and pop when full is forbidden (push requires ready); simultaneous push and pop when empty is not a bypass.
- level_O: pushes minus pops; pointer wrap-around at DEPTH is modulo.
- Flush: flush_I has priority over everything. On that edge the FIFO empties, decode_valid_O becomes 0, and any push presented the same cycle is dropped.
- Immediates:
  - I (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R (0110011): 0.
  - CSR immediate forms (funct3[2] = 1): {27'b0, instr[19:15]}; other CSR forms: 0.
- Flags:
  - SYSTEM funct3 = 000: imm 0 -> ecall; imm 1 -> ebreak.
  - MISC-MEM funct3 000 -> fence; 001 -> fence_i.
  - SYSTEM funct3 in {001, 010, 011, 101, 110, 111} with ENABLE_CSR = 1 -> csr_O.
- error_O = 1 (flags 0, fields still driven) when any of:
  - instr[1:0] != 11, or opcode not listed above;
  - JALR funct3 != 000;
  - branch funct3 in {010, 011};
  - load funct3 in {011, 110, 111};
  - store funct3 >= 011;
  - R-type funct7 not 0000000, or 0100000 with funct3 not in {000, 101};
  - OP-IMM shift (funct3 001/101) with illegal funct7;
  - SYSTEM funct3 = 000 with imm not in {0, 1}, or funct3 = 100;
  - any CSR form with ENABLE_CSR = 0;
  - MISC-MEM funct3 not in {000, 001}.

Test Plan:
- Reset, then push 0x00500093 (addi x1, x0, 5) at pc 0x100 -> one cycle later decode_valid_O = 1, rd = 1, rs1 = 0, imm32 = 0x00000005, pc_O = 0x100, error_O = 0.
- Push DEPTH+1 instructions with decode_ready_I = 0 -> instr_ready_O = 0 after DEPTH−... accepted total DEPTH+1 (DEPTH in FIFO + 1 in output stage); level_O = DEPTH. Releasing ready drains them in order, one per cycle.
- Decode 0xFFFFF0B7 (lui) -> imm32 = 0xFFFFF000. Decode 0xFE000EE3 (beq, offset −4) -> imm32 = 0xFFFFFFFC.
- Decode 0x40000033 -> error_O = 0 (sub). Decode 0x40001033 -> error_O = 1. Decode 0x00100073 -> ebreak_O = 1. Decode 0x30002573 (csrrs) with ENABLE_CSR = 0 -> error_O = 1, csr_O = 0.
- With 3 instructions queued and the output valid, assert flush_I together with instr_valid_I -> next cycle decode_valid_O = 0, level_O = 0, and the pushed instruction never appears.
- Assert rst while decode_valid_O = 1 and the FIFO is half full -> all outputs immediately 0, instr_ready_O = 1.
